// File: rtl/n_term_single2_loopback_bist.sv
// -----------------------------------------------------------------------------
// n_term_single2_loopback_bist
//
// North-edge termination tile for the single/double/quad routing wires. Every
// north-going wire is turned around onto its south-going partner with the bit
// order reversed inside each bundle. A small built-in self test can replace the
// turnaround with an LFSR pattern and check what comes back through an
// external loop of BIST_LAT cycles.
//
// Parameters
//   BIST_LAT  loop latency (cycles) from S outputs back to N inputs in BIST, 1..4
//   NUM_VEC   number of vectors compared per BIST run, 1..65535
//
// Ports
//   UserCLK                  clock, rising edge
//   RESETn                   asynchronous active-low reset
//   N1END/N2MID/N2END/N4END/NN4END   north-going wires in (4/8/8/16/16)
//   S1BEG/S2BEG/S2BEGb/S4BEG/SS4BEG  south-going wires out (4/8/8/16/16)
//   mode                     00 bypass, 01 registered, 10 BIST, 11 park
//   bist_start               one-cycle pulse, starts a run in BIST mode
//   bist_busy                high while a run is in progress
//   bist_done / bist_pass    run finished / finished without any error
//   err_cnt                  mismatching compare cycles, saturates at 255
// -----------------------------------------------------------------------------
module n_term_single2_loopback_bist #(
    parameter int BIST_LAT = 2,
    parameter int NUM_VEC  = 256
) (
    input  logic        UserCLK,
    input  logic        RESETn,
    input  logic [3:0]  N1END,
    input  logic [7:0]  N2MID,
    input  logic [7:0]  N2END,
    input  logic [15:0] N4END,
    input  logic [15:0] NN4END,
    output logic [3:0]  S1BEG,
    output logic [7:0]  S2BEG,
    output logic [7:0]  S2BEGb,
    output logic [15:0] S4BEG,
    output logic [15:0] SS4BEG,
    input  logic [1:0]  mode,
    input  logic        bist_start,
    output logic        bist_busy,
    output logic        bist_done,
    output logic        bist_pass,
    output logic [7:0]  err_cnt
);

    localparam logic [15:0] SEED      = 16'hACE1;
    localparam logic [16:0] FIRST_CMP = 17'(BIST_LAT);
    localparam logic [16:0] LAST_CYC  = 17'(NUM_VEC + BIST_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Generator word in {S1BEG,S2BEG,S2BEGb,S4BEG,SS4BEG} order. The inverted
    // copies make sure no bundle can be stuck at a constant and still pass.
    function automatic logic [51:0] gen_word(input logic [15:0] l);
        return {l[3:0], l[11:4], ~l[7:0], l[15:0], ~l[15:0]};
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    logic [51:0] in_word;
    logic [51:0] rev_word;
    logic [51:0] s_word;
    logic        is_bist;
    logic        mismatch;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] hist_q [BIST_LAT];
    logic [15:0] hist_d [BIST_LAT];
    logic [16:0] cyc_q, cyc_d;
    logic [7:0]  err_q, err_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [51:0] reg_path_q;

    assign in_word = {N1END, N2MID, N2END, N4END, NN4END};
    assign is_bist = (mode == 2'b10);

    // Bit reversal inside each bundle; the concatenated word keeps bundle order.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rev1
            assign rev_word[48 + gi] = N1END[3 - gi];
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_rev2
            assign rev_word[40 + gi] = N2MID[7 - gi];
            assign rev_word[32 + gi] = N2END[7 - gi];
        end
        for (genvar gi = 0; gi < 16; gi++) begin : g_rev4
            assign rev_word[16 + gi] = N4END[15 - gi];
            assign rev_word[gi]      = NN4END[15 - gi];
        end
    endgenerate

    // The oldest history entry is the LFSR state driven BIST_LAT cycles ago,
    // which is what should be arriving back on the N inputs now.
    assign mismatch = (in_word != gen_word(hist_q[BIST_LAT-1]));

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        hist_d  = hist_q;
        cyc_d   = cyc_q;
        err_d   = err_q;
        done_d  = done_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (is_bist && bist_start) begin
                    state_d = ST_RUN;
                    lfsr_d  = SEED;
                    cyc_d   = '0;
                    err_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (!is_bist) begin
                    // Aborted run: no verdict, but the error count stays visible.
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    lfsr_d    = lfsr_step(lfsr_q);
                    hist_d[0] = lfsr_q;
                    for (int k = 1; k < BIST_LAT; k++) begin
                        hist_d[k] = hist_q[k-1];
                    end
                    cyc_d = cyc_q + 17'd1;
                    if (cyc_q >= FIRST_CMP && mismatch && err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    if (cyc_q == LAST_CYC) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 8'd0);
                    end
                end
            end
            ST_DONE: begin
                if (!is_bist) begin
                    state_d = ST_IDLE;
                end else if (bist_start) begin
                    state_d = ST_RUN;
                    lfsr_d  = SEED;
                    cyc_d   = '0;
                    err_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge UserCLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= ST_IDLE;
            lfsr_q     <= SEED;
            hist_q     <= '{default: '0};
            cyc_q      <= '0;
            err_q      <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            reg_path_q <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            hist_q     <= hist_d;
            cyc_q      <= cyc_d;
            err_q      <= err_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            reg_path_q <= rev_word;
        end
    end

    always_comb begin
        s_word = '0;
        case (mode)
            2'b00:   s_word = rev_word;
            2'b01:   s_word = reg_path_q;
            2'b10:   s_word = gen_word(lfsr_q);
            default: s_word = '0;
        endcase
    end

    assign {S1BEG, S2BEG, S2BEGb, S4BEG, SS4BEG} = s_word;

    assign bist_busy = (state_q == ST_RUN);
    assign bist_done = done_q;
    assign bist_pass = pass_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_n_term_single2_loopback_bist.sv
module tb_n_term_single2_loopback_bist;

    localparam int LAT = 2;
    localparam int NV  = 256;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        UserCLK = 1'b0;
    logic        RESETn;
    logic [51:0] in_w;
    logic [3:0]  N1END;
    logic [7:0]  N2MID, N2END;
    logic [15:0] N4END, NN4END;
    logic [3:0]  S1BEG;
    logic [7:0]  S2BEG, S2BEGb;
    logic [15:0] S4BEG, SS4BEG;
    logic [1:0]  mode;
    logic        bist_start;
    logic        bist_busy, bist_done, bist_pass;
    logic [7:0]  err_cnt;
    logic [51:0] s_w;

    int checks   = 0;
    int failures = 0;

    // per-run loop controls and observations
    logic [51:0] flip_mask [0:299];
    int busy_cycles;
    int gen_bad;

    always #5 UserCLK = ~UserCLK;

    assign {N1END, N2MID, N2END, N4END, NN4END} = in_w;
    assign s_w = {S1BEG, S2BEG, S2BEGb, S4BEG, SS4BEG};

    n_term_single2_loopback_bist #(.BIST_LAT(LAT), .NUM_VEC(NV)) dut (
        .UserCLK    (UserCLK),
        .RESETn     (RESETn),
        .N1END      (N1END),
        .N2MID      (N2MID),
        .N2END      (N2END),
        .N4END      (N4END),
        .NN4END     (NN4END),
        .S1BEG      (S1BEG),
        .S2BEG      (S2BEG),
        .S2BEGb     (S2BEGb),
        .S4BEG      (S4BEG),
        .SS4BEG     (SS4BEG),
        .mode       (mode),
        .bist_start (bist_start),
        .bist_busy  (bist_busy),
        .bist_done  (bist_done),
        .bist_pass  (bist_pass),
        .err_cnt    (err_cnt)
    );

    // ---------------- reference model ----------------
    function automatic logic [51:0] ref_rev(input logic [51:0] w);
        logic [3:0]  a, ra;
        logic [7:0]  b, c, rb, rc;
        logic [15:0] d, e, rd, re;
        {a, b, c, d, e} = w;
        for (int i = 0; i < 4; i++)  ra[i] = a[3-i];
        for (int i = 0; i < 8; i++)  begin rb[i] = b[7-i]; rc[i] = c[7-i]; end
        for (int i = 0; i < 16; i++) begin rd[i] = d[15-i]; re[i] = e[15-i]; end
        return {ra, rb, rc, rd, re};
    endfunction

    function automatic logic [51:0] ref_g(input logic [15:0] l);
        return {l[3:0], l[11:4], ~l[7:0], l[15:0], ~l[15:0]};
    endfunction

    function automatic logic [15:0] ref_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [51:0] rnd52();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[51:0];
    endfunction

    // expected error count: corrupted cycles that fall in the compare window
    function automatic int expected_errs();
        int n;
        n = 0;
        for (int c = LAT; c < LAT + NV; c++) if (flip_mask[c] != '0) n++;
        return (n > 255) ? 255 : n;
    endfunction

    task automatic tick();
        @(posedge UserCLK);
        #1;
    endtask

    task automatic clear_flips();
        for (int i = 0; i < 300; i++) flip_mask[i] = '0;
    endtask

    // Drives one BIST run with the outputs looped back LAT cycles later,
    // applying flip_mask per RUN cycle. Records busy length and how many RUN
    // cycles drove a word differing from the modelled LFSR sequence.
    task automatic run_loop(input bit tie0, input int abort_at, input int extra_start_at);
        logic [51:0] q[$];
        logic [51:0] fed;
        logic [15:0] ml;
        int c;
        mode = 2'b10;
        in_w = '0;
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        ml = SEED;
        c = 0;
        busy_cycles = 0;
        gen_bad = 0;
        while (bist_busy === 1'b1 && c < 400) begin
            busy_cycles++;
            if (s_w !== ref_g(ml)) gen_bad++;
            q.push_back(s_w);
            if (q.size() > LAT) fed = q.pop_front();
            else fed = '0;
            if (tie0) fed = '0;
            else if (c < 300) fed = fed ^ flip_mask[c];
            in_w = fed;
            bist_start = (c == extra_start_at);
            if (c == abort_at) mode = 2'b00;
            ml = ref_next(ml);
            c++;
            tick();
        end
        bist_start = 1'b0;
        in_w = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [51:0] exp;
        RESETn = 1'b1;
        mode = 2'b00;
        bist_start = 1'b0;
        in_w = '0;
        #2 RESETn = 1'b0;
        tick();
        tick();
        checks++; if (bist_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bist_busy); end
        checks++; if (bist_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bist_done); end
        checks++; if (bist_pass !== 1'b0) begin failures++; $display("FAIL reset_pass: got %b expected 0", bist_pass); end
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            in_w = rnd52();
            #1;
            case (m)
                0: exp = ref_rev(in_w);
                2: exp = ref_g(SEED);
                default: exp = '0;
            endcase
            checks++;
            if (s_w !== exp) begin
                failures++;
                $display("FAIL reset_out_mode%0d: got %h expected %h", m, s_w, exp);
            end
        end
        // release away from the edge; BIST mode alone must not start a run
        mode = 2'b10;
        in_w = '0;
        @(negedge UserCLK);
        RESETn = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (bist_busy !== 1'b0) begin failures++; $display("FAIL reset_no_autostart: got busy=%b expected 0", bist_busy); end
        $display("test_reset done");
    endtask

    task automatic test_bypass();
        mode = 2'b00;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) in_w = {4'b0001, 8'h00, 8'h00, 16'h0001, 16'h0000};
            else in_w = rnd52();
            #1;
            checks++;
            if (s_w !== ref_rev(in_w)) begin
                failures++;
                $display("FAIL bypass[%0d]: got %h expected %h", i, s_w, ref_rev(in_w));
            end
            $display("bypass in=%h out=%h", in_w, s_w);
            tick();
        end
    endtask

    task automatic test_registered();
        logic [51:0] prev;
        mode = 2'b01;
        in_w = '0;
        tick();
        for (int i = 0; i < 6; i++) begin
            prev = ref_rev(in_w);
            if (i == 0) in_w = {4'h0, 8'h01, 8'h00, 16'h0000, 16'h0000};
            else in_w = rnd52();
            #1;
            checks++;
            if (s_w !== prev) begin
                failures++;
                $display("FAIL registered_before_edge[%0d]: got %h expected %h", i, s_w, prev);
            end
            tick();
            checks++;
            if (s_w !== ref_rev(in_w)) begin
                failures++;
                $display("FAIL registered_after_edge[%0d]: got %h expected %h", i, s_w, ref_rev(in_w));
            end
            $display("registered in=%h out=%h", in_w, s_w);
        end
    endtask

    task automatic test_park();
        mode = 2'b11;
        for (int i = 0; i < 4; i++) begin
            in_w = rnd52();
            #1;
            checks++;
            if (s_w !== '0) begin
                failures++;
                $display("FAIL park[%0d]: got %h expected 0", i, s_w);
            end
            tick();
        end
        $display("test_park done");
    endtask

    task automatic check_run(input string name, input int exp_busy, input int exp_err,
                             input logic exp_done, input logic exp_pass);
        checks++; if (busy_cycles !== exp_busy) begin failures++; $display("FAIL %s_busy_len: got %0d expected %0d", name, busy_cycles, exp_busy); end
        checks++; if (gen_bad !== 0) begin failures++; $display("FAIL %s_gen_word: got %0d bad cycles expected 0", name, gen_bad); end
        checks++; if (bist_done !== exp_done) begin failures++; $display("FAIL %s_done: got %b expected %b", name, bist_done, exp_done); end
        checks++; if (bist_pass !== exp_pass) begin failures++; $display("FAIL %s_pass: got %b expected %b", name, bist_pass, exp_pass); end
        checks++; if (err_cnt !== 8'(exp_err)) begin failures++; $display("FAIL %s_err_cnt: got %0d expected %0d", name, err_cnt, exp_err); end
        $display("run %s busy=%0d done=%b pass=%b err=%0d", name, busy_cycles, bist_done, bist_pass, err_cnt);
    endtask

    task automatic test_pass_run();
        clear_flips();
        run_loop(1'b0, -1, 100);   // stray bist_start mid-run must be ignored
        check_run("pass", LAT + NV, 0, 1'b1, 1'b1);
    endtask

    task automatic test_mode_leave_done();
        mode = 2'b01;
        tick();
        tick();
        checks++; if (bist_busy !== 1'b0) begin failures++; $display("FAIL leave_done_busy: got %b expected 0", bist_busy); end
        checks++; if (bist_done !== 1'b1) begin failures++; $display("FAIL leave_done_done: got %b expected 1", bist_done); end
        checks++; if (bist_pass !== 1'b1) begin failures++; $display("FAIL leave_done_pass: got %b expected 1", bist_pass); end
        $display("leave_done busy=%b done=%b pass=%b", bist_busy, bist_done, bist_pass);
    endtask

    task automatic test_flip3();
        int mid;
        clear_flips();
        mid = $urandom_range(100, 200);
        flip_mask[LAT]          = 52'b1 << $urandom_range(51, 0);
        flip_mask[mid]          = 52'b1 << $urandom_range(51, 0);
        flip_mask[LAT + NV - 1] = 52'b1 << $urandom_range(51, 0);
        flip_mask[0]            = 52'b1 << $urandom_range(51, 0); // before compares
        flip_mask[1]            = 52'b1 << $urandom_range(51, 0);
        run_loop(1'b0, -1, -1);
        check_run("flip3", LAT + NV, 3, 1'b1, 1'b0);
    endtask

    task automatic test_saturate();
        clear_flips();
        run_loop(1'b1, -1, -1);
        check_run("tie0", LAT + NV, 255, 1'b1, 1'b0);
    endtask

    task automatic test_random_flips();
        int k, e;
        for (int it = 0; it < 3; it++) begin
            clear_flips();
            k = $urandom_range(0, 20);
            for (int j = 0; j < k; j++) flip_mask[$urandom_range(0, LAT + NV + 1)] = rnd52() | 52'b1;
            e = expected_errs();
            run_loop(1'b0, -1, -1);
            check_run("random", LAT + NV, e, 1'b1, (e == 0));
        end
    endtask

    task automatic test_abort_run();
        clear_flips();
        flip_mask[10] = 52'h1;
        flip_mask[20] = 52'h8000000000000;
        run_loop(1'b0, 50, -1);
        check_run("abort", 51, 2, 1'b0, 1'b0);
    endtask

    task automatic test_reset_in_run();
        mode = 2'b10;
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            in_w = rnd52();
            tick();
        end
        RESETn = 1'b0;
        #1;
        checks++; if (bist_busy !== 1'b0) begin failures++; $display("FAIL rst_run_busy: got %b expected 0", bist_busy); end
        checks++; if (bist_done !== 1'b0) begin failures++; $display("FAIL rst_run_done: got %b expected 0", bist_done); end
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL rst_run_err: got %0d expected 0", err_cnt); end
        checks++; if (s_w !== ref_g(SEED)) begin failures++; $display("FAIL rst_run_out: got %h expected %h", s_w, ref_g(SEED)); end
        in_w = '0;
        tick();
        @(negedge UserCLK);
        RESETn = 1'b1;
        tick();
        tick();
        checks++; if (bist_busy !== 1'b0) begin failures++; $display("FAIL rst_run_idle: got %b expected 0", bist_busy); end
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        checks++; if (bist_busy !== 1'b1) begin failures++; $display("FAIL rst_run_restart_busy: got %b expected 1", bist_busy); end
        checks++; if (s_w !== ref_g(SEED)) begin failures++; $display("FAIL rst_run_cycle0: got %h expected %h", s_w, ref_g(SEED)); end
        tick();
        checks++; if (s_w !== ref_g(ref_next(SEED))) begin failures++; $display("FAIL rst_run_cycle1: got %h expected %h", s_w, ref_g(ref_next(SEED))); end
        $display("reset_in_run restart word=%h", s_w);
        mode = 2'b11;
        tick();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_registered();
        test_park();
        test_pass_run();
        test_mode_leave_done();
        test_flip3();
        test_saturate();
        test_random_flips();
        test_abort_run();
        test_reset_in_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/n_term_single2_loopback_bist.md
N_TERM_SINGLE2_LOOPBACK_BIST -- requirements
Module: n_term_single2_loopback_bist

Interface
REQ-001 SHALL have parameter BIST_LAT, default 2, legal 1..4: loop latency in cycles from S outputs back to N inputs during BIST.
REQ-002 SHALL have parameter NUM_VEC, default 256, legal 1..65535: number of vectors compared per BIST run.
REQ-003 SHALL have port UserCLK  in  1  the single clock, rising edge.
REQ-004 SHALL have port RESETn  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports N1END in 4, N2MID in 8, N2END in 8, N4END in 16, NN4END in 16: north-going wires arriving at the north fabric edge.
REQ-006 SHALL have ports S1BEG out 4, S2BEG out 8, S2BEGb out 8, S4BEG out 16, SS4BEG out 16: south-going wires leaving the north fabric edge.
REQ-007 SHALL have port mode  in  2  00 bypass, 01 registered, 10 BIST, 11 park; static configuration.
REQ-008 SHALL have ports bist_start in 1 (one-cycle pulse), bist_busy out 1, bist_done out 1, bist_pass out 1, err_cnt out 8.

Function
REQ-009 SHALL define the reversed word R: S1BEG[i]=N1END[3-i], S2BEG[i]=N2MID[7-i], S2BEGb[i]=N2END[7-i], S4BEG[i]=N4END[15-i], SS4BEG[i]=NN4END[15-i].
REQ-010 mode 00: S outputs SHALL equal R combinationally, zero latency.
REQ-011 mode 01: S outputs SHALL equal R registered on UserCLK, exactly one cycle latency.
REQ-012 mode 11: all S outputs SHALL be 0.
REQ-013 mode 10: S outputs SHALL be generator word G = {S1BEG,S2BEG,S2BEGb,S4BEG,SS4BEG} = {lfsr[3:0], lfsr[11:4], ~lfsr[7:0], lfsr[15:0], ~lfsr[15:0]}, driven from the lfsr register.
REQ-014 lfsr SHALL be 16-bit Fibonacci, next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}, seed 16'hACE1, advancing once per RUN cycle only.
REQ-015 FSM states: IDLE, RUN, DONE.
REQ-016 IDLE->RUN on bist_start=1 while mode=10; entering RUN SHALL reload lfsr with seed, clear err_cnt, clear bist_done and bist_pass.
REQ-017 RUN SHALL last exactly NUM_VEC+BIST_LAT cycles; RUN cycle 0 drives the seed word.
REQ-018 In RUN cycle c with c>=BIST_LAT, checker SHALL compare input word I = {N1END,N2MID,N2END,N4END,NN4END} with G of RUN cycle c-BIST_LAT, held in a BIST_LAT-deep history of lfsr states; exactly NUM_VEC compares per run.
REQ-019 Any bit mismatch in a compare cycle SHALL increment err_cnt by 1, saturating at 255.
REQ-020 RUN->DONE after final compare; bist_done=1, bist_pass=1 iff err_cnt==0; DONE holds lfsr and outputs.
REQ-021 DONE->RUN on bist_start; bist_start in RUN SHALL be ignored.
REQ-022 mode leaving 10 in RUN or DONE SHALL force IDLE next cycle; bist_done, bist_pass unchanged if from DONE, 0 if aborted from RUN; err_cnt retained.
REQ-023 bist_busy SHALL be 1 exactly in RUN.

Reset
REQ-024 RESETn low SHALL asynchronously force: state IDLE, lfsr=16'hACE1, history=0, registered-path register=0, err_cnt=0, bist_busy=0, bist_done=0, bist_pass=0.
REQ-025 During reset, S outputs SHALL be 0 in modes 01 and 11, R in mode 00, seed word G(16'hACE1) in mode 10.
REQ-026 Reset deassertion SHALL take effect on the next UserCLK edge; no BIST run starts without a fresh bist_start.

Verification
REQ-027 mode 00, N1END=4'b0001, N4END=16'h0001 -> same cycle S1BEG=4'b1000, S4BEG=16'h8000.
REQ-028 mode 01, N2MID=8'h01 set before edge n -> S2BEG=8'h80 after edge n, 8'h00 before edge n.
REQ-029 mode 10, bench feeds outputs back to I with 2-cycle delay, bist_start pulse -> busy for 258 cycles, then done=1, pass=1, err_cnt=0.
REQ-030 Same loop, one bit flipped in 3 distinct compare cycles -> done=1, pass=0, err_cnt=3.
REQ-031 mode 10, all N inputs tied 0 -> err_cnt=255 (saturated), pass=0.
REQ-032 RESETn low in RUN cycle 100 -> busy=0, done=0, err_cnt=0 immediately; next bist_start drives seed word 16'hACE1 in RUN cycle 0.
